// File: rtl/bus_responder_6502.sv
// Memory and peripheral responder for the 6502 external bus.
// Valid/ready style: the CPU owns the bus cycle; rdy=0 holds the current
// cycle, and a cycle completes on the posedge where rdy=1. The TX FIFO
// transfers its head byte on every posedge where tx_valid & tx_ready.
// The low 32 KiB is RAM. The I/O page is decoded from the high address byte.
// The rest of the upper half is ROM, loaded through the ld_* side port.
module bus_responder_6502 #(
  parameter int          WAIT_STATES = 0,
  parameter int          TRAP_COUNT  = 3,
  parameter logic [7:0]  IO_PAGE     = 8'hF0
) (
  input  logic        phi0,
  input  logic        res,
  input  logic [15:0] ab,
  input  logic        rw,
  input  logic        sync,
  input  logic [7:0]  db_in,
  output logic [7:0]  db_out,
  output logic        db_oe,
  output logic        rdy,
  input  logic        ld_we,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        trap,
  output logic [15:0] trap_pc
);

  localparam logic [3:0] WS    = 4'(WAIT_STATES);
  localparam logic [7:0] TC_M1 = 8'(TRAP_COUNT - 1);

  logic [7:0]  mem [0:65535];
  logic [7:0]  fifo [0:3];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        ovf;
  logic [3:0]  wcnt;
  logic [7:0]  scnt;
  logic [15:0] last_pc;

  logic io_hit, rom_hit, cpu_we, full, push, push_ok, pop, ovf_clr, fetch;

  assign io_hit  = ab[15] && (ab[15:8] == IO_PAGE);
  assign rom_hit = ab[15] && !io_hit;
  // A ROM read is held until wcnt has counted the programmed wait states.
  // Reset forces rdy high so that a stalled CPU is released immediately.
  assign rdy     = res ? 1'b1 : !(rw && rom_hit && (wcnt < WS));
  assign db_oe   = rw & ~res;
  // A preload write in the same cycle takes priority over the CPU write.
  assign cpu_we  = !rw && !res && rdy && !ld_we;
  assign full    = (count == 3'd4);
  assign tx_valid = (count != 3'd0);
  assign tx_data  = fifo[rd_ptr];
  assign pop      = tx_valid && tx_ready;
  assign push     = cpu_we && io_hit && (ab[7:0] == 8'h00);
  // When the FIFO is full, a pop in the same cycle frees the slot for the push.
  assign push_ok  = push && (!full || pop);
  assign ovf_clr  = cpu_we && io_hit && (ab[7:0] == 8'h01);
  assign fetch    = sync && rdy && !res;

  // Combinational read mux: memory, or I/O registers in the I/O page
  always_comb begin
    db_out = mem[ab];
    if (io_hit) begin
      case (ab[7:0])
        8'h00:   db_out = 8'h00;
        8'h01:   db_out = {trap, 5'b0, ovf, ~full};
        default: db_out = 8'hFF;
      endcase
    end
  end

  // Memory array: preload port first, then CPU RAM writes; never reset
  always_ff @(posedge phi0) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end else if (cpu_we && !ab[15]) begin
      mem[ab] <= db_in;
    end
  end

  // FIFO storage: data slots carry no reset value
  always_ff @(posedge phi0) begin
    if (push_ok) begin
      fifo[wr_ptr] <= db_in;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge phi0 or posedge res) begin
    if (res) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      ovf    <= 1'b0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (push && !push_ok) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // Wait-state counter: advances while stalled, clears on a completed cycle
  always_ff @(posedge phi0 or posedge res) begin
    if (res) begin
      wcnt <= 4'd0;
    end else if (!rdy) begin
      wcnt <= wcnt + 4'd1;
    end else begin
      wcnt <= 4'd0;
    end
  end

  // Self-loop detector over completed opcode fetches; trap is sticky
  always_ff @(posedge phi0 or posedge res) begin
    if (res) begin
      scnt    <= 8'd0;
      last_pc <= 16'h0000;
      trap    <= 1'b0;
      trap_pc <= 16'h0000;
    end else if (fetch) begin
      if (ab == last_pc) begin
        if (scnt != 8'hFF) scnt <= scnt + 8'd1;
        if (scnt >= TC_M1 && !trap) begin
          trap    <= 1'b1;
          trap_pc <= ab;
        end
      end else begin
        scnt    <= 8'd1;
        last_pc <= ab;
      end
    end
  end

endmodule

// File: tb/tb_bus_responder_6502.sv
// Directed bench for bus_responder_6502 with a bus-level reference model.
module tb_bus_responder_6502;

  localparam int WS = 2;
  localparam int TC = 3;

  // ---------------- clock / reset ----------------
  logic        phi0 = 1'b0;
  logic        res;
  logic [15:0] ab;
  logic        rw, sync, ld_we, tx_ready;
  logic [7:0]  db_in, ld_data;
  logic [15:0] ld_addr;
  logic [7:0]  db_out, tx_data;
  logic        db_oe, rdy, tx_valid, trap;
  logic [15:0] trap_pc;

  always #5 phi0 = ~phi0;

  bus_responder_6502 #(.WAIT_STATES(WS), .TRAP_COUNT(TC), .IO_PAGE(8'hF0)) dut (
    .phi0(phi0), .res(res), .ab(ab), .rw(rw), .sync(sync), .db_in(db_in),
    .db_out(db_out), .db_oe(db_oe), .rdy(rdy), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .trap(trap), .trap_pc(trap_pc)
  );

  int checks = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [7:0]  mem_m [0:65535];
  bit          known [0:65535];
  logic [7:0]  exp_q[$];
  bit          ovf_m = 0, trap_m = 0;
  logic [15:0] trap_pc_m = 0, last_pc_m = 0;
  int          run_m = 0, stall_m = 0;

  function automatic bit is_io(input logic [15:0] a);
    return a[15:8] == 8'hF0;
  endfunction

  function automatic bit is_rom(input logic [15:0] a);
    return a[15] && !is_io(a);
  endfunction

  function automatic bit exp_rdy();
    if (res) return 1'b1;
    return !(rw && is_rom(ab) && stall_m < WS);
  endfunction

  always @(posedge phi0) begin
    if (ld_we) begin
      mem_m[ld_addr] = ld_data;
      known[ld_addr] = 1'b1;
    end else if (!res && !rw && !ab[15]) begin
      mem_m[ab] = db_in;
      known[ab] = 1'b1;
    end
  end

  always @(posedge phi0 or posedge res) begin : model_upd
    bit r, popped, wr_ok;
    int n;
    if (res) begin
      exp_q.delete();
      ovf_m = 0; trap_m = 0; trap_pc_m = 0; last_pc_m = 0; run_m = 0; stall_m = 0;
    end else begin
      r      = exp_rdy();
      n      = exp_q.size();
      popped = (n > 0) && tx_ready;
      wr_ok  = !rw && !ld_we;
      if (popped) void'(exp_q.pop_front());
      if (wr_ok && is_io(ab) && ab[7:0] == 8'h00) begin
        if (n < 4 || popped) exp_q.push_back(db_in);
        else ovf_m = 1;
      end
      if (wr_ok && is_io(ab) && ab[7:0] == 8'h01) ovf_m = 0;
      if (sync && r) begin
        if (ab == last_pc_m) begin
          if (run_m + 1 >= TC && !trap_m) begin
            trap_m = 1;
            trap_pc_m = ab;
          end
          run_m = (run_m < 255) ? run_m + 1 : 255;
        end else begin
          run_m = 1;
          last_pc_m = ab;
        end
      end
      stall_m = r ? 0 : stall_m + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge phi0) begin : compare
    logic [7:0] e;
    if (res) begin
      check("rst_rdy", rdy, 1);
      check("rst_db_oe", db_oe, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_trap", trap, 0);
      check("rst_trap_pc", trap_pc, 0);
    end else begin
      check("rdy", rdy, exp_rdy());
      check("db_oe", db_oe, rw);
      check("tx_valid", tx_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("tx_data", tx_data, exp_q[0]);
      check("trap", trap, trap_m);
      check("trap_pc", trap_pc, trap_pc_m);
      if (rw) begin
        if (is_io(ab)) begin
          if (ab[7:0] == 8'h00) e = 8'h00;
          else if (ab[7:0] == 8'h01) e = {trap_m, 5'b0, ovf_m, exp_q.size() < 4};
          else e = 8'hFF;
          check("db_out_io", db_out, e);
        end else if (known[ab]) begin
          check("db_out_mem", db_out, mem_m[ab]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic ld(input logic [15:0] a, input logic [7:0] d);
    ld_addr = a; ld_data = d; ld_we = 1'b1;
    @(posedge phi0); #1;
    ld_we = 1'b0;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    ab = a; rw = 1'b0; sync = 1'b0; db_in = d;
    @(posedge phi0); #1;
  endtask

  // Read cycle held until rdy; returns data seen on the completing cycle,
  // the number of stalled cycles and whether db_out held steady throughout.
  task automatic bus_rd(input logic [15:0] a, input logic s, output logic [7:0] d,
                        output int stalls, output bit stable);
    logic [7:0] first;
    bit r;
    ab = a; rw = 1'b1; sync = s;
    stalls = 0; stable = 1; r = 0; d = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge phi0);
      r = rdy; d = db_out;
      if (i == 0) first = db_out;
      else if (db_out !== first) stable = 0;
      @(posedge phi0); #1;
      if (r) break;
      stalls++;
    end
    if (!r) check("read_timeout", 0, 1);
    sync = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  logic [7:0] prog [10] = '{8'hD8, 8'hA2, 8'hFF, 8'h9A, 8'hCA, 8'hA9, 8'h55, 8'h48, 8'hD0, 8'hFB};
  bit         op   [10] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 0};
  logic [7:0] drain1 [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
  logic [7:0] drain2 [4] = '{8'h62, 8'h63, 8'h64, 8'h65};

  task automatic drain(input logic [7:0] exp_b [4]);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge phi0);
      check("drain_valid", tx_valid, 1);
      check("drain_data", tx_data, exp_b[i]);
      @(posedge phi0); #1;
    end
    tx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int st;
    bit stb;
    res = 1; ab = 16'h0000; rw = 1; sync = 0; db_in = 0;
    ld_we = 0; ld_addr = 0; ld_data = 0; tx_ready = 0;

    @(negedge phi0);
    check("reset_rdy", rdy, 1);
    check("reset_db_oe", db_oe, 0);
    check("reset_tx_valid", tx_valid, 0);
    @(posedge phi0); #1;

    // Preload under reset: vector, program, ROM data, loop bodies
    ld(16'hFFFC, 8'h00);
    ld(16'hFFFD, 8'h10);
    for (int i = 0; i < 10; i++) ld(16'h1000 + 16'(i), prog[i]);
    ld(16'h8000, 8'h5A);
    ld(16'h9000, 8'h33);
    ld(16'h2000, 8'h4C); ld(16'h2001, 8'h00); ld(16'h2002, 8'h20);
    ld(16'h3000, 8'h4C); ld(16'h3001, 8'h00); ld(16'h3002, 8'h30);
    ab = 16'h1000;
    res = 0;

    // Reset vector from ROM, each with two wait states
    bus_rd(16'hFFFC, 0, d, st, stb);
    check("vec_lo", d, 8'h00); check("vec_lo_stalls", st, 2);
    bus_rd(16'hFFFD, 0, d, st, stb);
    check("vec_hi", d, 8'h10);

    // Program fetch from RAM: no stalls
    for (int i = 0; i < 10; i++) begin
      bus_rd(16'h1000 + 16'(i), op[i], d, st, stb);
      check("prog_byte", d, prog[i]);
      check("prog_stalls", st, 0);
    end
    bus_wr(16'h01FF, 8'h55);
    bus_rd(16'h1007, 1, d, st, stb);
    bus_wr(16'h01FE, 8'h55);
    bus_rd(16'h1007, 1, d, st, stb);
    bus_wr(16'h01FD, 8'h55);
    bus_rd(16'h01FE, 0, d, st, stb);
    check("stack_01fe", d, 8'h55);
    bus_rd(16'h01FD, 0, d, st, stb);
    check("stack_01fd", d, 8'h55);

    // ROM wait states followed by an unstalled RAM read
    bus_rd(16'h8000, 0, d, st, stb);
    check("rom_stalls", st, 2); check("rom_data", d, 8'h5A); check("rom_db_stable", stb, 1);
    bus_rd(16'h1000, 0, d, st, stb);
    check("ram_after_rom_stalls", st, 0);

    // ROM write ignored, RAM top byte written
    bus_wr(16'h9000, 8'hAA);
    bus_rd(16'h9000, 0, d, st, stb);
    check("rom_unchanged", d, 8'h33);
    bus_wr(16'h7FFF, 8'hAA);
    bus_rd(16'h7FFF, 0, d, st, stb);
    check("ram_7fff", d, 8'hAA);

    // FIFO overflow and drain
    for (int i = 0; i < 5; i++) bus_wr(16'hF000, 8'h41 + 8'(i));
    bus_rd(16'hF001, 0, d, st, stb);
    check("status_ovf_full", d, 8'h02);
    bus_rd(16'hF000, 0, d, st, stb);
    check("io_data_reg", d, 8'h00);
    bus_rd(16'hF0A5, 0, d, st, stb);
    check("io_other", d, 8'hFF);
    ab = 16'h1000; rw = 1;
    drain(drain1);
    check("fifo_empty_after_drain", tx_valid, 0);
    bus_wr(16'hF001, 8'h00);
    bus_rd(16'hF001, 0, d, st, stb);
    check("status_ovf_cleared", d, 8'h01);

    // Push into a full FIFO while popping: accepted, no overflow
    for (int i = 0; i < 4; i++) bus_wr(16'hF000, 8'h61 + 8'(i));
    tx_ready = 1;
    bus_wr(16'hF000, 8'h65);
    tx_ready = 0;
    bus_rd(16'hF001, 0, d, st, stb);
    check("status_full_no_ovf", d, 8'h00);
    ab = 16'h1000; rw = 1;
    drain(drain2);

    // Self-loop at 0x2000 traps on the third opcode fetch
    for (int k = 0; k < 3; k++) begin
      if (k == 2) check("trap_before_third", trap, 0);
      bus_rd(16'h2000, 1, d, st, stb);
      if (k == 2) begin
        check("trap_set", trap, 1);
        check("trap_pc", trap_pc, 16'h2000);
      end
      bus_rd(16'h2001, 0, d, st, stb);
      bus_rd(16'h2002, 0, d, st, stb);
    end
    bus_rd(16'hF001, 0, d, st, stb);
    check("status_trap", d, 8'h81);
    for (int k = 0; k < 3; k++) bus_rd(16'h3000, 1, d, st, stb);
    check("trap_pc_sticky", trap_pc, 16'h2000);

    // Asynchronous reset during a ROM stall with two queued bytes
    bus_wr(16'hF000, 8'h11);
    bus_wr(16'hF000, 8'h22);
    ab = 16'h8000; rw = 1; sync = 0;
    @(negedge phi0);
    check("pre_rst_rdy", rdy, 0);
    check("pre_rst_tx_valid", tx_valid, 1);
    #2 res = 1;
    #1;
    check("async_rdy", rdy, 1);
    check("async_tx_valid", tx_valid, 0);
    check("async_trap", trap, 0);
    check("async_db_oe", db_oe, 0);
    check("async_trap_pc", trap_pc, 16'h0000);
    @(posedge phi0); @(posedge phi0); #1;
    ab = 16'h1000;
    res = 0;
    bus_rd(16'h7FFF, 0, d, st, stb);
    check("mem_kept_over_reset", d, 8'hAA);
    check("fifo_empty_after_reset", tx_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
